// File: rtl/dr32e_fetch_fifo.sv
// Instruction prefetch FIFO and RV32IC realigner that feeds the IF-ID register.
// Latency: a pushed word is presented at the output one cycle after the push.
// Backpressure: in_ready_o follows the registered count, and out_valid_o does not depend on out_ready_i.
module dr32e_fetch_fifo #(
   parameter int DEPTH = 3
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       clear_i,
   input  logic [31:0]                clear_addr_i,
   input  logic                       in_valid_i,
   output logic                       in_ready_o,
   input  logic [31:0]                in_rdata_i,
   input  logic                       in_err_i,
   output logic                       out_valid_o,
   input  logic                       out_ready_i,
   output logic [31:0]                out_rdata_o,
   output logic [31:0]                out_addr_o,
   output logic                       out_compressed_o,
   output logic                       out_err_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [31:0]      mem_rdata [DEPTH];
   logic [DEPTH-1:0] mem_err;
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr_nxt;
   logic [CW-1:0]    count;
   logic [31:0]      addr;

   logic [31:0] w0;
   logic [15:0] w1_lo;
   logic        e0;
   logic        e1;
   logic        push;
   logic        pop;
   logic        fire;
   logic [31:0] addr_step;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign rd_ptr_nxt = ptr_inc(rd_ptr);
   assign w0         = mem_rdata[rd_ptr];
   assign w1_lo      = mem_rdata[rd_ptr_nxt][15:0];
   assign e0         = mem_err[rd_ptr];
   assign e1         = mem_err[rd_ptr_nxt];

   assign in_ready_o = (count < CW'(DEPTH));
   assign count_o    = count;
   assign out_addr_o = addr;

   // Realign head entries into one instruction; a straddle with an erroring first word is emitted without W1
   always_comb begin
      out_valid_o = 1'b0;
      out_err_o   = 1'b0;
      out_rdata_o = '0;
      if (count != '0) begin
         if (!addr[1]) begin
            out_valid_o = 1'b1;
            out_err_o   = e0;
            out_rdata_o = (w0[1:0] != 2'b11) ? {16'h0, w0[15:0]} : w0;
         end else if (w0[17:16] != 2'b11) begin
            out_valid_o = 1'b1;
            out_err_o   = e0;
            out_rdata_o = {16'h0, w0[31:16]};
         end else if (count >= CW'(2)) begin
            out_valid_o = 1'b1;
            out_err_o   = e0 | e1;
            out_rdata_o = {w1_lo, w0[31:16]};
         end else if (e0) begin
            // Upper half keeps rdata[1:0]=2'b11, so the PC still advances by 4 past the bad word
            out_valid_o = 1'b1;
            out_err_o   = 1'b1;
            out_rdata_o = {16'h0, w0[31:16]};
         end
      end
      out_compressed_o = out_valid_o && (out_rdata_o[1:0] != 2'b11);
   end

   assign fire      = out_valid_o && out_ready_i;
   assign addr_step = addr + (out_compressed_o ? 32'd2 : 32'd4);
   // The head word is finished once the new PC leaves it: any consume from the upper half, or a full word from the lower half
   assign pop       = fire && (addr[1] || !out_compressed_o);
   assign push      = in_valid_i && in_ready_o && !clear_i;

   // Pointer, count and PC bookkeeping; a flush overrides push and consume
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         addr   <= '0;
      end else if (clear_i) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         addr   <= {clear_addr_i[31:1], clear_addr_i[0] & 1'b0};
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= rd_ptr_nxt;
         if (fire) addr   <= addr_step;
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Word storage; contents are only observed while count covers them, so no reset is needed
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_rdata[wr_ptr] <= in_rdata_i;
         mem_err[wr_ptr]   <= in_err_i;
      end
   end

endmodule

// File: tb/tb_dr32e_fetch_fifo.sv
// Directed bench for dr32e_fetch_fifo with a queue-based output scoreboard.
// Stimulus changes inputs 1ns after the rising edge; the monitor samples on the falling edge.
// Expected instructions are queued by the stimulus and popped by the monitor on each consume.
module tb_dr32e_fetch_fifo;

   localparam int DEPTH = 3;

   typedef struct packed {
      logic [31:0] rdata;
      logic [31:0] addr;
      logic        comp;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        clear = 1'b0;
   logic [31:0] clear_addr = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_rdata = '0;
   logic        in_err = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_rdata;
   logic [31:0] out_addr;
   logic        out_compressed;
   logic        out_err;
   logic [$clog2(DEPTH+1)-1:0] count;

   int   total = 0;
   int   bad = 0;
   exp_t sb[$];

   dr32e_fetch_fifo #(.DEPTH(DEPTH)) dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .clear_i          (clear),
      .clear_addr_i     (clear_addr),
      .in_valid_i       (in_valid),
      .in_ready_o       (in_ready),
      .in_rdata_i       (in_rdata),
      .in_err_i         (in_err),
      .out_valid_o      (out_valid),
      .out_ready_i      (out_ready),
      .out_rdata_o      (out_rdata),
      .out_addr_o       (out_addr),
      .out_compressed_o (out_compressed),
      .out_err_o        (out_err),
      .count_o          (count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input logic [31:0] rdata, input logic [31:0] addr,
                             input logic comp, input logic err);
      exp_t e;
      e.rdata = rdata;
      e.addr  = addr;
      e.comp  = comp;
      e.err   = err;
      sb.push_back(e);
   endtask

   task automatic do_clear(input logic [31:0] a);
      clear = 1'b1;
      clear_addr = a;
      tick();
      clear = 1'b0;
   endtask

   task automatic push_word(input logic [31:0] d, input logic e);
      in_valid = 1'b1;
      in_rdata = d;
      in_err = e;
      tick();
      in_valid = 1'b0;
      in_err = 1'b0;
   endtask

   task automatic consume(input int n);
      out_ready = 1'b1;
      repeat (n) tick();
      out_ready = 1'b0;
   endtask

   // Monitor: every accepted instruction is matched against the head of the scoreboard
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && !clear && out_valid && out_ready) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_out: got rdata %h addr %h want no output", out_rdata, out_addr);
            end else begin
               e = sb.pop_front();
               chk("out_addr", out_addr, e.addr);
               chk("out_err", {31'h0, out_err}, {31'h0, e.err});
               if (!e.err) begin
                  chk("out_rdata", out_rdata, e.rdata);
                  chk("out_compressed", {31'h0, out_compressed}, {31'h0, e.comp});
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want test end");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      #1 rst = 1'b1;
      tick();
      tick();
      chk("rst_count", {30'h0, count}, 32'd0);
      chk("rst_valid", {31'h0, out_valid}, 32'd0);
      chk("rst_addr", out_addr, 32'h0);
      chk("rst_in_ready", {31'h0, in_ready}, 32'd1);
      rst = 1'b0;

      // Single 32-bit instruction
      expect_out(32'h00000013, 32'h0, 1'b0, 1'b0);
      push_word(32'h00000013, 1'b0);
      chk("s1_valid", {31'h0, out_valid}, 32'd1);
      chk("s1_count", {30'h0, count}, 32'd1);
      consume(1);
      chk("s1_addr", out_addr, 32'h4);
      chk("s1_count_after", {30'h0, count}, 32'd0);

      // Two compressed halves in one word
      do_clear(32'h0);
      expect_out(32'h00004501, 32'h0, 1'b1, 1'b0);
      expect_out(32'h00004501, 32'h2, 1'b1, 1'b0);
      push_word(32'h45014501, 1'b0);
      out_ready = 1'b1;
      tick();
      chk("s2_count_mid", {30'h0, count}, 32'd1);
      tick();
      out_ready = 1'b0;
      chk("s2_count_end", {30'h0, count}, 32'd0);
      chk("s2_valid_end", {31'h0, out_valid}, 32'd0);

      // Halfword start with a straddling instruction
      do_clear(32'h102);
      push_word(32'h02934501, 1'b0);
      for (int i = 0; i < 3; i++) begin
         chk("s3_wait_valid", {31'h0, out_valid}, 32'd0);
         tick();
      end
      expect_out(32'h00500293, 32'h102, 1'b0, 1'b0);
      push_word(32'h00000050, 1'b0);
      chk("s3_valid", {31'h0, out_valid}, 32'd1);
      chk("s3_count", {30'h0, count}, 32'd2);
      consume(1);
      chk("s3_addr", out_addr, 32'h106);
      chk("s3_count_after", {30'h0, count}, 32'd1);

      // Fill to DEPTH, then push while full during consumption
      do_clear(32'h0);
      for (int i = 0; i < 6; i++) expect_out(32'h00004501, 32'(2 * i), 1'b1, 1'b0);
      in_valid = 1'b1;
      in_rdata = 32'h45014501;
      repeat (3) tick();
      chk("s4_full_count", {30'h0, count}, 32'd3);
      chk("s4_full_ready", {31'h0, in_ready}, 32'd0);
      in_rdata = 32'hdeadbeef;
      out_ready = 1'b1;
      tick();
      chk("s4_count_c1", {30'h0, count}, 32'd3);
      tick();
      in_valid = 1'b0;
      chk("s4_count_c2", {30'h0, count}, 32'd2);
      chk("s4_ready_c2", {31'h0, in_ready}, 32'd1);
      repeat (4) tick();
      out_ready = 1'b0;
      chk("s4_count_end", {30'h0, count}, 32'd0);
      chk("s4_addr_end", out_addr, 32'hc);
      chk("s4_valid_end", {31'h0, out_valid}, 32'd0);

      // Erroring word at a straddle is emitted without waiting for W1
      do_clear(32'h2);
      expect_out(32'h0, 32'h2, 1'b0, 1'b1);
      push_word(32'h00030000, 1'b1);
      chk("s5_valid", {31'h0, out_valid}, 32'd1);
      chk("s5_err", {31'h0, out_err}, 32'd1);
      consume(1);
      chk("s5_count_after", {30'h0, count}, 32'd0);

      // Flush mid-straddle with push and consume requested
      do_clear(32'h2);
      push_word(32'h00130000, 1'b0);
      push_word(32'h00000000, 1'b0);
      chk("s6_count", {30'h0, count}, 32'd2);
      chk("s6_valid", {31'h0, out_valid}, 32'd1);
      clear = 1'b1;
      clear_addr = 32'h40;
      in_valid = 1'b1;
      in_rdata = 32'h11111111;
      out_ready = 1'b1;
      tick();
      clear = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      chk("s6_clr_count", {30'h0, count}, 32'd0);
      chk("s6_clr_valid", {31'h0, out_valid}, 32'd0);
      chk("s6_clr_addr", out_addr, 32'h40);
      tick();
      chk("s6_clr_count2", {30'h0, count}, 32'd0);

      // Asynchronous reset mid-stream
      push_word(32'h00000013, 1'b0);
      chk("s7_valid_pre", {31'h0, out_valid}, 32'd1);
      #1 rst = 1'b1;
      #1;
      chk("s7_rst_valid", {31'h0, out_valid}, 32'd0);
      chk("s7_rst_addr", out_addr, 32'h0);
      chk("s7_rst_count", {30'h0, count}, 32'd0);
      chk("s7_rst_rdata", out_rdata, 32'h0);
      chk("s7_rst_err", {31'h0, out_err}, 32'd0);
      tick();
      rst = 1'b0;
      tick();
      tick();
      chk("sb_empty", sb.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
